dma_io_peripheral: RTL and testbench

Single-channel DMA-capable I/O peripheral that sits directly upstream/downstream of the `dma` controller on the shared bus. It raises DREQ toward one controller channel and answers DACK with IOR_N/IOW_N bus cycles. It buffers data in an internal FIFO and exchanges it with local logic through valid/ready ports. It is the device end of every I/O-to-memory and memory-to-I/O transfer the controller runs.

---
 rtl/dma_io_peripheral.sv | 196 +++++++++++++++++++
 tb/tb_dma_io_peripheral.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_io_peripheral.sv
// Device end of a single DMA channel: raises DREQ, answers DACK with IOR_N/IOW_N
// strobes and buffers data in a FIFO shared with valid/ready local ports.
module dma_io_peripheral #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         enable,
    input  logic                         mode,
    output logic                         DREQ,
    input  logic                         DACK,
    input  logic                         IOR_N,
    input  logic                         IOW_N,
    input  logic                         EOP_N,
    input  logic [DATA_WIDTH-1:0]        dataIn,
    output logic [DATA_WIDTH-1:0]        dataOut,
    output logic                         dataOe,
    input  logic                         srcValid,
    input  logic [DATA_WIDTH-1:0]        srcData,
    output logic                         srcReady,
    output logic                         sinkValid,
    output logic [DATA_WIDTH-1:0]        sinkData,
    input  logic                         sinkReady,
    output logic [$clog2(DEPTH):0]       fifoCount,
    output logic                         tcSeen,
    output logic                         overrun,
    output logic                         underrun
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam int unsigned   CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_ACTIVE,
        S_STROBE,
        S_TERM
    } state_e;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  dreq_q, dreq_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  tc_q, tc_d;
    logic                  over_q, over_d;
    logic                  under_q, under_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  strobe_n;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH-1:0] head;
    logic                  commit;
    logic                  term_hit;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;

    assign strobe_n = mode_q ? IOW_N : IOR_N;
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];
    assign commit   = enable && (state_q == S_STROBE) && strobe_n;
    assign term_hit = enable && (state_q != S_IDLE) && !EOP_N && DACK;

    // State register, plus the registered DREQ.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b1;
            dreq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dreq_q  <= dreq_d;
        end
    end

    // Next-state logic: enable dominates, then EOP with DACK, then the bus handshake.
    always_comb begin
        state_d = state_q;
        // Mode tracks the input while IDLE, so the value on the IDLE->ARMED edge sticks.
        mode_d  = (state_q == S_IDLE) ? mode : mode_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else if (term_hit) begin
            state_d = S_TERM;
        end else begin
            unique case (state_q)
                S_IDLE:   state_d = S_ARMED;
                S_ARMED:  if (DACK) state_d = S_ACTIVE;
                S_ACTIVE: begin
                    if (!DACK)          state_d = S_ARMED;
                    else if (!strobe_n) state_d = S_STROBE;
                end
                S_STROBE: if (strobe_n) state_d = DACK ? S_ACTIVE : S_ARMED;
                S_TERM:   state_d = S_TERM;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        dreq_d = 1'b0;
        if (state_q inside {S_ARMED, S_ACTIVE, S_STROBE}) begin
            dreq_d = mode_q ? !full : !empty;
        end
        dataOut = '0;
        if (!mode_q && !empty &&
            ((state_q == S_STROBE) || ((state_q == S_ACTIVE) && DACK && !IOR_N))) begin
            dataOut = head;
        end
        dataOe    = DACK && !IOR_N && !mode_q;
        srcReady  = !mode_q && !full;
        sinkValid = mode_q && !empty;
        sinkData  = sinkValid ? head : '0;
        DREQ      = dreq_q;
        fifoCount = count_q;
        tcSeen    = tc_q;
        overrun   = over_q;
        underrun  = under_q;
    end

    // FIFO and flag datapath; bus and local sides never push (or pop) in the same mode.
    always_comb begin
        logic local_push;
        logic local_pop;
        logic bus_push;
        logic bus_pop;

        local_push = srcValid && srcReady;
        local_pop  = sinkValid && sinkReady;
        bus_pop    = commit && !mode_q && !empty;
        bus_push   = commit && mode_q && !full;
        push       = local_push || bus_push;
        pop        = local_pop || bus_pop;
        push_data  = mode_q ? wdata_q : srcData;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        wdata_d = wdata_q;
        if (mode_q && !IOW_N && (state_q inside {S_ACTIVE, S_STROBE})) begin
            wdata_d = dataIn;
        end

        if (!enable) begin
            tc_d    = 1'b0;
            over_d  = 1'b0;
            under_d = 1'b0;
        end else begin
            tc_d    = tc_q || term_hit;
            over_d  = over_q || (commit && mode_q && full);
            under_d = under_q || (commit && !mode_q && empty);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wdata_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tc_q     <= 1'b0;
            over_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            wdata_q  <= wdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tc_q     <= tc_d;
            over_q   <= over_d;
            under_q  <= under_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Self-checking bench for dma_io_peripheral: directed scenarios with random data
// plus random traffic, checked against a queue-based reference model.
module tb_dma_io_peripheral;

    localparam int unsigned DEPTH = 16;

    logic       CLK;
    logic       RESET;
    logic       enable;
    logic       mode;
    logic       DREQ;
    logic       DACK;
    logic       IOR_N;
    logic       IOW_N;
    logic       EOP_N;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic       dataOe;
    logic       srcValid;
    logic [7:0] srcData;
    logic       srcReady;
    logic       sinkValid;
    logic [7:0] sinkData;
    logic       sinkReady;
    logic [4:0] fifoCount;
    logic       tcSeen;
    logic       overrun;
    logic       underrun;

    dma_io_peripheral #(.DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .enable(enable), .mode(mode), .DREQ(DREQ),
        .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
        .dataIn(dataIn), .dataOut(dataOut), .dataOe(dataOe),
        .srcValid(srcValid), .srcData(srcData), .srcReady(srcReady),
        .sinkValid(sinkValid), .sinkData(sinkData), .sinkReady(sinkReady),
        .fifoCount(fifoCount), .tcSeen(tcSeen), .overrun(overrun), .underrun(underrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0] mq[$];
    bit         exp_tc;
    bit         exp_over;
    bit         exp_under;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_flags_model;
        exp_tc    = 1'b0;
        exp_over  = 1'b0;
        exp_under = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_count"}, 32'(fifoCount), 32'(mq.size()));
        check_eq({tag, "_tc"}, 32'(tcSeen), 32'(exp_tc));
        check_eq({tag, "_over"}, 32'(overrun), 32'(exp_over));
        check_eq({tag, "_under"}, 32'(underrun), 32'(exp_under));
    endtask

    task automatic push_local(input logic [7:0] d);
        bit ok;
        ok       = (mq.size() < DEPTH);
        srcValid = 1'b1;
        srcData  = d;
        #1;
        check_eq("srcReady", 32'(srcReady), 32'(ok));
        tick;
        srcValid = 1'b0;
        if (ok) mq.push_back(d);
    endtask

    // One IOR_N pulse (low one cycle, then high); optional EOP and local push on the commit cycle.
    task automatic bus_read(input bit eop, input bit do_push, input logic [7:0] pd);
        logic [7:0] exp_d;
        IOR_N = 1'b0;
        #1;
        check_eq("dataOe", 32'(dataOe), 32'd1);
        tick;
        IOR_N = 1'b1;
        EOP_N = !eop;
        if (do_push) begin
            srcValid = 1'b1;
            srcData  = pd;
        end
        #1;
        exp_d = (mq.size() > 0) ? mq[0] : 8'h00;
        check_eq("rd_data", 32'(dataOut), 32'(exp_d));
        tick;
        EOP_N    = 1'b1;
        srcValid = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        else exp_under = 1'b1;
        if (do_push) mq.push_back(pd);
        if (eop) exp_tc = 1'b1;
    endtask

    task automatic bus_write(input logic [7:0] d);
        IOW_N  = 1'b0;
        dataIn = d;
        tick;
        IOW_N  = 1'b1;
        dataIn = 8'($urandom);
        tick;
        if (mq.size() < DEPTH) mq.push_back(d);
        else exp_over = 1'b1;
    endtask

    task automatic sink_pop;
        sinkReady = 1'b1;
        #1;
        check_eq("sinkValid", 32'(sinkValid), 32'(mq.size() > 0));
        if (mq.size() > 0) check_eq("sinkData", 32'(sinkData), 32'(mq[0]));
        tick;
        sinkReady = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b0; enable = 1'b0; mode = 1'b0; DACK = 1'b0;
        IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1; dataIn = '0;
        srcValid = 1'b0; srcData = '0; sinkReady = 1'b0;
        clear_flags_model();
        tick; tick;
        RESET = 1'b1;
        #1;
        check_eq("rst_DREQ", 32'(DREQ), 32'd0);
        check_eq("rst_dataOe", 32'(dataOe), 32'd0);
        check_eq("rst_dataOut", 32'(dataOut), 32'd0);
        check_eq("rst_srcReady", 32'(srcReady), 32'd0);
        check_eq("rst_sinkValid", 32'(sinkValid), 32'd0);
        check_status("rst");

        // Mode 0: three local pushes then three bus reads.
        tick;
        push_local(8'hA1); push_local(8'hB2); push_local(8'hC3);
        check_status("m0_fill");
        enable = 1'b1;
        tick; tick;
        check_eq("m0_dreq_hi", 32'(DREQ), 32'd1);
        DACK = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) bus_read(1'b0, 1'b0, 8'h00);
        tick;
        check_eq("m0_dreq_lo", 32'(DREQ), 32'd0);
        check_status("m0_drain");

        // Mode 1: DEPTH writes, one overrun, then sink drain.
        DACK = 1'b0; enable = 1'b0; mode = 1'b1;
        tick; tick;
        clear_flags_model();
        enable = 1'b1;
        tick; tick;
        check_eq("m1_dreq_hi", 32'(DREQ), 32'd1);
        DACK = 1'b1;
        tick;
        for (int i = 0; i < DEPTH; i++) bus_write(8'(i));
        tick;
        check_eq("m1_dreq_full", 32'(DREQ), 32'd0);
        check_status("m1_full");
        bus_write(8'($urandom));
        check_status("m1_overrun");
        for (int i = 0; i < DEPTH; i++) sink_pop();
        check_status("m1_drain");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) bus_write(8'($urandom));
            else sink_pop();
            check_status("m1_rand");
        end
        while (mq.size() > 0) sink_pop();
        DACK = 1'b0; enable = 1'b0;
        tick;
        clear_flags_model();
        check_status("m1_clear");

        // EOP during the second of four reads.
        mode = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) push_local(8'($urandom));
        enable = 1'b1;
        tick;
        DACK = 1'b1;
        tick;
        bus_read(1'b0, 1'b0, 8'h00);
        bus_read(1'b1, 1'b0, 8'h00);
        tick;
        check_eq("eop_dreq", 32'(DREQ), 32'd0);
        for (int i = 0; i < 2; i++) begin
            IOR_N = 1'b0; tick;
            IOR_N = 1'b1; tick;
        end
        check_eq("eop_dreq_hold", 32'(DREQ), 32'd0);
        check_status("eop_term");
        DACK = 1'b0; enable = 1'b0;
        tick;
        clear_flags_model();
        check_status("eop_clear");
        enable = 1'b1;
        tick; tick;
        check_eq("eop_dreq_back", 32'(DREQ), 32'd1);
        DACK = 1'b1;
        tick;

        // Same-cycle local push and bus pop at fifoCount=1.
        bus_read(1'b0, 1'b0, 8'h00);
        check_status("same_pre");
        bus_read(1'b0, 1'b1, 8'($urandom));
        check_status("same_cycle");
        bus_read(1'b0, 1'b0, 8'h00);
        check_status("same_after");

        // Underrun on an empty FIFO with DACK forced.
        bus_read(1'b0, 1'b0, 8'h00);
        check_status("underrun");

        // Random mode-0 traffic.
        enable = 1'b0; tick;
        clear_flags_model();
        enable = 1'b1; tick; tick;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0) push_local(8'($urandom));
            else bus_read(1'b0, 1'b0, 8'h00);
            check_status("m0_rand");
        end

        // Asynchronous reset while in STROBE with five entries.
        DACK = 1'b0; enable = 1'b0;
        RESET = 1'b0; tick; RESET = 1'b1;
        mq.delete();
        clear_flags_model();
        tick;
        for (int i = 0; i < 5; i++) push_local(8'($urandom));
        enable = 1'b1; tick;
        DACK = 1'b1; tick; tick;
        IOR_N = 1'b0;
        tick;
        #2;
        RESET = 1'b0;
        #1;
        mq.delete();
        check_eq("arst_DREQ", 32'(DREQ), 32'd0);
        check_eq("arst_dataOe", 32'(dataOe), 32'd0);
        check_eq("arst_dataOut", 32'(dataOut), 32'd0);
        check_eq("arst_srcReady", 32'(srcReady), 32'd0);
        check_eq("arst_sinkValid", 32'(sinkValid), 32'd0);
        check_status("arst");
        IOR_N = 1'b1;
        tick; tick;
        RESET = 1'b1;
        tick; tick; tick;
        check_status("arst_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
